// File: rtl/uart_event_encoder.sv
// rtl/uart_event_encoder.sv - latches event pulses and emits ASCII status bytes over a valid/ready byte port (optional CR/LF suffix via UART_EVENT_CRLF_EN)
module uart_event_encoder #(
    parameter logic [7:0] CHAR_0 = 8'h41,
    parameter logic [7:0] CHAR_1 = 8'h57,
    parameter logic [7:0] CHAR_2 = 8'h53,
    parameter logic [7:0] CHAR_3 = 8'h44,
    parameter logic [7:0] CHAR_4 = 8'h42,
    parameter logic [7:0] CHAR_5 = 8'h4E,
    parameter logic [7:0] CHAR_6 = 8'h4D
) (
    input  logic       I_sys_clk,
    input  logic       I_rst,
    input  logic [6:0] I_event,
    input  logic       I_tx_ready,
    output logic [7:0] O_tx_data,
    output logic       O_tx_valid,
    output logic [6:0] O_drop,
    output logic       O_busy
);

`ifdef UART_EVENT_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t     state;
    logic [6:0] pend;
    logic [2:0] sel_idx;
    logic       sel_any;
    logic [6:0] clr;
    logic [7:0] sel_char;
    logic       xfer;

    assign xfer   = O_tx_valid & I_tx_ready;
    assign O_busy = (state != IDLE) | (|pend);

    // Fixed-priority pick of the lowest pending index; only IDLE consumes it.
    always_comb begin
        sel_idx = 3'd0;
        sel_any = |pend;
        for (int i = 6; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = i[2:0];
            end
        end
        clr = ((state == IDLE) && sel_any) ? (7'd1 << sel_idx) : 7'd0;
        case (sel_idx)
            3'd0:    sel_char = CHAR_0;
            3'd1:    sel_char = CHAR_1;
            3'd2:    sel_char = CHAR_2;
            3'd3:    sel_char = CHAR_3;
            3'd4:    sel_char = CHAR_4;
            3'd5:    sel_char = CHAR_5;
            3'd6:    sel_char = CHAR_6;
            default: sel_char = 8'h00;
        endcase
    end

    // Pending latch: a new pulse wins over a same-cycle clear; a pulse on an
    // already-pending, not-cleared bit coalesces and is reported as a drop.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            pend   <= 7'd0;
            O_drop <= 7'd0;
        end else begin
            pend   <= I_event | (pend & ~clr);
            O_drop <= I_event & pend & ~clr;
        end
    end

    // Byte sequencer: arbitration happens only in IDLE, so a character and its
    // optional CR/LF suffix always leave back to back.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state      <= IDLE;
            O_tx_data  <= 8'h00;
            O_tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        O_tx_data  <= sel_char;
                        O_tx_valid <= 1'b1;
                        state      <= SEND;
                    end else begin
                        O_tx_valid <= 1'b0;
                    end
                end
                SEND: begin
                    if (xfer) begin
`ifdef UART_EVENT_CRLF_EN
                        O_tx_data <= 8'h0D;
                        state     <= CR;
`else
                        O_tx_valid <= 1'b0;
                        state      <= IDLE;
`endif
                    end
                end
`ifdef UART_EVENT_CRLF_EN
                CR: begin
                    if (xfer) begin
                        O_tx_data <= 8'h0A;
                        state     <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        O_tx_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
`endif
                default: begin
                    O_tx_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_event_encoder.sv
// tb/tb_uart_event_encoder.sv - queue-model checked bench for uart_event_encoder
module tb_uart_event_encoder;

    logic       I_sys_clk = 1'b0;
    logic       I_rst = 1'b1;
    logic [6:0] I_event = 7'd0;
    logic       I_tx_ready = 1'b1;
    logic [7:0] O_tx_data;
    logic       O_tx_valid;
    logic [6:0] O_drop;
    logic       O_busy;

    uart_event_encoder dut (
        .I_sys_clk  (I_sys_clk),
        .I_rst      (I_rst),
        .I_event    (I_event),
        .I_tx_ready (I_tx_ready),
        .O_tx_data  (O_tx_data),
        .O_tx_valid (O_tx_valid),
        .O_drop     (O_drop),
        .O_busy     (O_busy)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    localparam logic [7:0] CH [7] = '{8'h41, 8'h57, 8'h53, 8'h44, 8'h42, 8'h4E, 8'h4D};

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: bytes of the character in flight sit in a queue; a new character
    // is only started on an edge where the queue was already empty.
    logic [6:0] m_pend = 7'd0;
    logic [6:0] m_drop = 7'd0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] q[$];

    always @(posedge I_sys_clk or posedge I_rst) begin : model
        bit was_empty;
        logic [6:0] clr;
        int k;
        if (I_rst) begin
            q.delete();
            m_pend = 7'd0;
            m_drop = 7'd0;
            m_last = 8'h00;
        end else begin
            was_empty = (q.size() == 0);
            clr = 7'd0;
            if (!was_empty && I_tx_ready) void'(q.pop_front());
            if (was_empty && m_pend != 0) begin
                k = 0;
                for (int i = 6; i >= 0; i--) if (m_pend[i]) k = i;
                clr[k] = 1'b1;
                q.push_back(CH[k]);
`ifdef UART_EVENT_CRLF_EN
                q.push_back(8'h0D);
                q.push_back(8'h0A);
`endif
            end
            m_drop = I_event & m_pend & ~clr;
            m_pend = I_event | (m_pend & ~clr);
            if (q.size() != 0) m_last = q[0];
        end
    end

    always @(posedge I_sys_clk) cyc++;

    // Transfer log and drop accumulator (inputs are stable at the falling edge).
    logic [7:0] xf[$];
    int         xc[$];
    logic [6:0] drop_or = 7'd0;

    // Per-cycle comparison of every output against the model.
    always @(negedge I_sys_clk) begin
        if (cyc > 0) begin
            chk("cmp_valid", {7'd0, O_tx_valid}, {7'd0, q.size() != 0});
            chk("cmp_data", O_tx_data, m_last);
            chk("cmp_drop", {1'b0, O_drop}, {1'b0, m_drop});
            chk("cmp_busy", {7'd0, O_busy}, {7'd0, (q.size() != 0) || (m_pend != 0)});
            if (!I_rst && O_tx_valid && I_tx_ready) begin
                xf.push_back(O_tx_data);
                xc.push_back(cyc);
            end
            drop_or = drop_or | O_drop;
        end
    end

    logic [7:0] exp_xf[$];

    task automatic step(input logic [6:0] ev, input logic rdy);
        @(posedge I_sys_clk);
        #2;
        I_event = ev;
        I_tx_ready = rdy;
    endtask

    task automatic begin_test();
        xf.delete();
        xc.delete();
        exp_xf.delete();
        drop_or = 7'd0;
    endtask

    task automatic exp_char(input logic [7:0] c);
        exp_xf.push_back(c);
`ifdef UART_EVENT_CRLF_EN
        exp_xf.push_back(8'h0D);
        exp_xf.push_back(8'h0A);
`endif
    endtask

    task automatic check_xfers(input string name);
        chk({name, "_count"}, 8'(xf.size()), 8'(exp_xf.size()));
        for (int i = 0; i < exp_xf.size() && i < xf.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), xf[i], exp_xf[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge I_sys_clk);
        #2 I_rst = 1'b0;

        // Idle after reset
        begin_test();
        repeat (20) step(7'd0, 1'b1);
        chk("idle_valid", {7'd0, O_tx_valid}, 8'h00);
        chk("idle_data", O_tx_data, 8'h00);
        chk("idle_busy", {7'd0, O_busy}, 8'h00);
        chk("idle_drop", {1'b0, O_drop}, 8'h00);
        check_xfers("idle");

        // Single pulse, two-cycle latency
        begin_test();
        exp_char(8'h41);
        step(7'b0000001, 1'b1);
        step(7'd0, 1'b1);
        chk("lat_valid_early", {7'd0, O_tx_valid}, 8'h00);
        step(7'd0, 1'b1);
        chk("lat_valid", {7'd0, O_tx_valid}, 8'h01);
        chk("lat_data", O_tx_data, 8'h41);
        repeat (8) step(7'd0, 1'b1);
        check_xfers("single");
        chk("single_busy", {7'd0, O_busy}, 8'h00);

        // Simultaneous events in priority order
        begin_test();
        exp_char(8'h57);
        exp_char(8'h44);
        exp_char(8'h4D);
        step(7'b1001010, 1'b1);
        repeat (20) step(7'd0, 1'b1);
        check_xfers("multi");
`ifndef UART_EVENT_CRLF_EN
        for (int i = 0; i + 1 < xc.size(); i++)
            chk($sformatf("multi_gap%0d", i), 8'(xc[i+1] - xc[i]), 8'd2);
`endif

        // Backpressure, re-queue during stall, drop while pending
        begin_test();
        exp_char(8'h53);
        exp_char(8'h53);
        step(7'b0000100, 1'b0);
        step(7'd0, 1'b0);
        step(7'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step((i == 3 || i == 6) ? 7'b0000100 : 7'd0, 1'b0);
            chk($sformatf("stall_valid%0d", i), {7'd0, O_tx_valid}, 8'h01);
            chk($sformatf("stall_data%0d", i), O_tx_data, 8'h53);
        end
        repeat (20) step(7'd0, 1'b1);
        check_xfers("stall");
        chk("stall_drop", {1'b0, drop_or}, 8'h04);

        // Set/clear collision: pulse again on the selection cycle
        begin_test();
        exp_char(8'h42);
        exp_char(8'h42);
        step(7'b0010000, 1'b1);
        step(7'b0010000, 1'b1);
        repeat (15) step(7'd0, 1'b1);
        check_xfers("collide");
        chk("collide_drop", {1'b0, drop_or}, 8'h00);

`ifdef UART_EVENT_CRLF_EN
        // CR stall with a new event queued behind the suffix
        begin_test();
        exp_char(8'h4D);
        exp_char(8'h41);
        step(7'b1000000, 1'b0);
        step(7'd0, 1'b0);
        step(7'd0, 1'b0);
        step(7'd0, 1'b1);
        step(7'b0000001, 1'b0);
        repeat (4) begin
            step(7'd0, 1'b0);
            chk("cr_data", O_tx_data, 8'h0D);
        end
        repeat (20) step(7'd0, 1'b1);
        check_xfers("crlf");
`endif

        // Reset in the middle of a transfer
        step(7'b0000001, 1'b0);
        step(7'd0, 1'b0);
        step(7'd0, 1'b0);
        chk("rst_pre_valid", {7'd0, O_tx_valid}, 8'h01);
        begin_test();
        #1 I_rst = 1'b1;
        #1;
        chk("rst_valid", {7'd0, O_tx_valid}, 8'h00);
        chk("rst_busy", {7'd0, O_busy}, 8'h00);
        chk("rst_data", O_tx_data, 8'h00);
        @(posedge I_sys_clk);
        #2 I_rst = 1'b0;
        repeat (6) step(7'd0, 1'b1);
        check_xfers("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_event_encoder.md
Name: uart_event_encoder

Overview:
Transmit-side counterpart of the UART command decoder: converts one-cycle event/acknowledge pulses from the cube controller (move done, scanner events, resets) into ASCII status characters for the UART transmitter. Each event is latched as pending, arbitrated by fixed priority, and handed to the UART TX byte interface over a valid/ready handshake. Sits between the controller/scanner logic and the UART TX serializer.

Parameters:
CHAR_0, 8'h41, code sent for event 0 ('A', left move done)
CHAR_1, 8'h57, event 1 ('W', top move done)
CHAR_2, 8'h53, event 2 ('S', bottom move done)
CHAR_3, 8'h44, event 3 ('D', right move done)
CHAR_4, 8'h42, event 4 ('B', scanner started)
CHAR_5, 8'h4E, event 5 ('N', scanner reset done)
CHAR_6, 8'h4D, event 6 ('M', user reset done)

Ports:
I_sys_clk  in  1  system clock, all logic on rising edge
I_rst  in  1  reset, asynchronous, active-high
I_event  in  7  event pulses, one cycle each; any combination may be high together
I_tx_ready  in  1  UART TX can accept a byte this cycle
O_tx_data  out  8  byte to transmit, registered
O_tx_valid  out  1  O_tx_data valid, registered
O_drop  out  7  one-cycle pulse per bit: event k arrived while already pending, registered
O_busy  out  1  high when state != IDLE or any pending bit set

Behaviour:
- Reset (async, immediate): O_tx_data=8'h00, O_tx_valid=0, O_drop=0, pending=0, state=IDLE; O_busy=0. Reset mid-transfer abandons the byte; no partial resume.
- Pending register pend[6:0]: at each edge, pend[k] <= 1 if I_event[k]; else cleared if selected by IDLE this cycle; else held. Set wins over same-cycle clear (new event queued, no drop).
- Drop: I_event[k]=1 while pend[k]=1 and k not being cleared this cycle -> O_drop[k]=1 next cycle; pending stays 1 (events coalesce).
- Handshake: transfer occurs on an edge where O_tx_valid=1 and I_tx_ready=1. While valid and not ready, O_tx_data held stable, O_tx_valid held high indefinitely.
- FSM states: IDLE, SEND (+ CR, LF with option).
  - IDLE: if pend!=0, select lowest set index k, clear pend[k], O_tx_data<=CHAR_k, O_tx_valid<=1, ->SEND. Else stay, O_tx_valid=0.
  - SEND: on transfer -> without option: O_tx_valid<=0, ->IDLE; with option: O_tx_data<=8'h0D, ->CR. No transfer: hold.
- Latency: I_event[k] high at edge E -> pend[k] set at E -> O_tx_valid=1 with CHAR_k after edge E+1 (2 cycles from pulse, if IDLE).
- Throughput: after transfer one IDLE cycle (valid low) before next byte; with I_tx_ready stuck high, one character per 2 cycles.
- Priority is fixed, bit 0 highest; a continuously re-pulsed low index can starve higher indices (accepted; controller events are sparse).
- Pulses arriving while in SEND/CR/LF are only queued; never affect the byte in flight.

Optional Feature:
UART_EVENT_CRLF_EN defined: each status character followed by 8'h0D then 8'h0A. CR: data 8'h0D, on transfer O_tx_data<=8'h0A, ->LF. LF: on transfer O_tx_valid<=0, ->IDLE. Pending arbitration only in IDLE, so the triple is never interleaved. Undefined: CR/LF states absent, single byte per event.

Test Plan:
- Reset then idle, I_tx_ready=1: O_tx_valid=0, O_tx_data=8'h00, O_busy=0, O_drop=0 for 20 cycles; assert I_rst mid-SEND -> O_tx_valid drops immediately.
- Single pulse I_event=7'b0000001, I_tx_ready=1: O_tx_valid high 2 cycles after pulse with 8'h41, exactly one transfer, O_busy returns 0.
- Simultaneous I_event=7'b1001010: bytes sent in order 8'h57, 8'h44, 8'h4D, each valid cycle separated by one idle cycle.
- Backpressure: event 2 with I_tx_ready=0 for 10 cycles -> O_tx_valid=1, O_tx_data=8'h53 stable all 10 cycles; transfer on ready rise; pulse event 2 again during stall -> queued, sent once afterward; pulse it a third time while pending -> O_drop=7'b0000100 for one cycle.
- Set/clear collision: pulse event 4 on exact cycle IDLE selects pending event 4 -> two 8'h42 bytes sent, O_drop stays 0.
- With UART_EVENT_CRLF_EN: event 6 -> sequence 8'h4D, 8'h0D, 8'h0A; event 0 pulsed during CR stall sent only after 8'h0A.
